// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole design.
// The screen uses the same NO_BOX encoding for "no mole up".
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP,
        DONE
    } state_t;

    localparam logic [3:0] NO_BOX    = 4'hF;
    localparam int         NUM_BOXES = 10;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Shifts every clock so game randomness depends on start timing.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: random mole selection, timing and scoring.
// Drives the screen's selected_box; NO_BOX means no mole is up.
module mole_game_ctrl #(
    parameter int         NUM_BOXES  = mole_pkg::NUM_BOXES,
    parameter int         UP_CYCLES  = 100_000_000,
    parameter int         GAP_CYCLES = 25_000_000,
    parameter int         ROUNDS     = 30,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_BOXES-1:0] hit,
    output logic [3:0]           selected_box,
    output logic [7:0]           score,
    output logic [7:0]           round,
    output logic                 game_over
);

    import mole_pkg::*;

    localparam int TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] UP_LOAD  = TW'(UP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]    ROUNDS_L = 8'(ROUNDS);
    localparam logic [3:0]    LAST_BOX = 4'(NUM_BOXES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    prev_box;
    logic [7:0]    lfsr;
    logic [3:0]    cand;
    logic [3:0]    next_box;
    logic          hit_act;

    lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk(clk),
        .rst(rst),
        .q  (lfsr)
    );

    // Never show the same box twice in a row.
    always_comb begin
        cand     = 4'(32'(lfsr) % NUM_BOXES);
        next_box = cand;
        if (cand == prev_box) begin
            next_box = (cand == LAST_BOX) ? 4'd0 : cand + 4'd1;
        end
    end

    always_comb begin
        hit_act = 1'b0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            if (selected_box == 4'(i)) begin
                hit_act = hit[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            selected_box <= NO_BOX;
            score        <= 8'd0;
            round        <= 8'd0;
            game_over    <= 1'b0;
            timer        <= '0;
            prev_box     <= NO_BOX;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    selected_box <= NO_BOX;
                    if (start) begin
                        state     <= GAP;
                        score     <= 8'd0;
                        round     <= 8'd0;
                        game_over <= 1'b0;
                        timer     <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (round == ROUNDS_L) begin
                        state     <= DONE;
                        game_over <= 1'b1;
                    end else begin
                        state        <= UP;
                        selected_box <= next_box;
                        prev_box     <= next_box;
                        round        <= round + 8'd1;
                        timer        <= UP_LOAD;
                    end
                end
                UP: begin
                    // A hit on the last cycle beats the timeout.
                    if (hit_act) begin
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                        state        <= GAP;
                        selected_box <= NO_BOX;
                        timer        <= GAP_LOAD;
                    end else if (timer == '0) begin
                        state        <= GAP;
                        selected_box <= NO_BOX;
                        timer        <= GAP_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    selected_box <= NO_BOX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed self-checking bench for mole_game_ctrl.
// Small-parameter build: 20-cycle moles, 5-cycle gaps, 3 rounds.
module tb_mole_game_ctrl;

    localparam int NB     = 10;
    localparam int UP     = 20;
    localparam int GAP    = 5;
    localparam int ROUNDS = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NB-1:0] hit;
    logic [3:0]    selected_box;
    logic [7:0]    score;
    logic [7:0]    round;
    logic          game_over;

    int         total;
    int         bad;
    int         exp_score;
    int         exp_round;
    logic [3:0] last_box;
    logic [7:0] m_q;
    logic [7:0] m_used;

    mole_game_ctrl #(
        .NUM_BOXES (NB),
        .UP_CYCLES (UP),
        .GAP_CYCLES(GAP),
        .ROUNDS    (ROUNDS),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hit         (hit),
        .selected_box(selected_box),
        .score       (score),
        .round       (round),
        .game_over   (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR; m_used is the value the DUT saw before the last edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= 8'hA5;
            m_used <= 8'hA5;
        end else begin
            m_used <= m_q;
            m_q    <= {m_q[6:0], ^(m_q & 8'hB8)};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_gap(input bit inject);
        for (int i = 0; i < GAP; i++) begin
            check("gap_sel", 32'(selected_box), 32'hF);
            check("gap_score", 32'(score), 32'(exp_score));
            check("gap_over", 32'(game_over), 32'd0);
            if (inject && i == 1) hit = '1;
            else hit = '0;
            @(negedge clk);
        end
        hit = '0;
    endtask

    task automatic run_up(input int mode);
        logic [3:0] box;
        logic [3:0] cand;
        logic [3:0] want;
        cand = 4'(32'(m_used) % NB);
        want = cand;
        if (cand == last_box) want = (cand == 4'(NB - 1)) ? 4'd0 : cand + 4'd1;
        box = selected_box;
        check("box_pick", 32'(box), 32'(want));
        check("box_range", 32'(box < 4'(NB)), 32'd1);
        check("box_repeat", 32'(box != last_box), 32'd1);
        last_box = box;
        exp_round++;
        check("round", 32'(round), 32'(exp_round));
        for (int i = 0; i < UP; i++) begin
            check("up_sel", 32'(selected_box), 32'(box));
            check("up_score", 32'(score), 32'(exp_score));
            if ((mode == 1 && i == 3) || (mode == 2 && i == UP - 1)) begin
                hit = NB'(1) << box;
                @(negedge clk);
                hit = '0;
                exp_score++;
                check("hit_score", 32'(score), 32'(exp_score));
                check("hit_clear", 32'(selected_box), 32'hF);
                return;
            end
            if (mode == 2 && i == 1) hit = NB'(1) << ((int'(box) + 1) % NB);
            @(negedge clk);
            hit = '0;
        end
    endtask

    task automatic play_game(input int mode_first, input int mode_rest,
                             input bit inject);
        start_pulse();
        exp_score = 0;
        exp_round = 0;
        check("start_round", 32'(round), 32'd0);
        for (int r = 0; r < ROUNDS; r++) begin
            run_gap(inject && r == 0);
            run_up(r == 0 ? mode_first : mode_rest);
        end
        run_gap(1'b0);
        check("done_over", 32'(game_over), 32'd1);
        check("done_sel", 32'(selected_box), 32'hF);
        check("done_round", 32'(round), 32'(ROUNDS));
        check("done_score", 32'(score), 32'(exp_score));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_score = 0;
        exp_round = 0;
        last_box  = 4'hF;
        rst       = 1'b1;
        start     = 1'b0;
        hit       = '0;
        repeat (3) @(negedge clk);
        check("rst_out", {selected_box, score, round, 3'b0, game_over},
              {4'hF, 8'd0, 8'd0, 4'd0});
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_out", {selected_box, score, round, 3'b0, game_over},
                  {4'hF, 8'd0, 8'd0, 4'd0});
        end

        play_game(0, 0, 1'b0);
        play_game(1, 1, 1'b0);
        play_game(2, 0, 1'b1);

        for (int g = 0; g < 50; g++) begin
            play_game(0, 0, 1'b0);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            check("done_hold", {game_over, round}, {1'b1, 8'(ROUNDS)});
        end

        start_pulse();
        exp_score = 0;
        exp_round = 0;
        run_gap(1'b0);
        run_up(1);
        run_gap(1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst_score", 32'(score), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out", {selected_box, score, round, 3'b0, game_over},
              {4'hF, 8'd0, 8'd0, 4'd0});
        @(negedge clk);
        rst      = 1'b0;
        last_box = 4'hF;
        @(negedge clk);
        check("post_rst_idle", {selected_box, score, round, 3'b0, game_over},
              {4'hF, 8'd0, 8'd0, 4'd0});
        play_game(1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game controller for the whack-a-mole design: picks a pseudo-random box, shows it as the active mole for a fixed window, and scores player hits. It sits directly upstream of the 10-box VGA screen and drives that screen's `selected_box` input. `selected_box` = 4'hF means no mole is up; the screen then shows all boxes red.

## Interface
Parameters:
- `NUM_BOXES`, 10: number of boxes (1–15).
- `UP_CYCLES`, 100_000_000: clk cycles a mole stays up (1 s at 100 MHz).
- `GAP_CYCLES`, 25_000_000: clk cycles with no mole between rounds.
- `ROUNDS`, 30: moles per game (1–255).
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  100 MHz system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse; starts a game from IDLE or DONE.
- `hit`  in  NUM_BOXES  single-cycle pulses, one bit per box; already debounced upstream.
- `selected_box`  out  4  active mole index 0..NUM_BOXES-1, or 4'hF for none.
- `score`  out  8  correct hits this game.
- `round`  out  8  moles presented this game.
- `game_over`  out  1  high in DONE.

## Operation
- Reset values: state = IDLE, `selected_box` = 4'hF, `score` = 0, `round` = 0, `game_over` = 0, LFSR = `LFSR_SEED`, timer = 0, prev_box = 4'hF.
- LFSR:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - Shifts every clk, including while idle, so the sequence depends on when the player presses `start`.
  - Candidate box = LFSR % NUM_BOXES.
  - If the candidate equals prev_box, use candidate+1, wrapping NUM_BOXES-1 → 0.
- State machine:
  - IDLE: `selected_box` = F.
    - `start` → GAP. Clears `score` and `round`, loads the timer with GAP_CYCLES-1.
  - GAP: `selected_box` = F; timer counts down.
    - At timer = 0: if `round` == ROUNDS → DONE.
    - Otherwise → UP. Latch the candidate into `selected_box` and prev_box, `round` += 1, load the timer with UP_CYCLES-1.
  - UP:
    - If `hit[selected_box]` = 1: `score` += 1 (saturate at 255) → GAP, timer = GAP_CYCLES-1.
    - Else if timer = 0 (miss): → GAP, timer = GAP_CYCLES-1.
    - Else the timer decrements.
  - DONE: `game_over` = 1, `selected_box` = F; `score` and `round` hold.
    - `start` → GAP, as from IDLE.
- Hit rules:
  - Bits of `hit` other than the active box are ignored; there is no penalty.
  - All `hit` is ignored outside UP.
  - Multiple bits set in one cycle: only the active-box bit matters.
- `start` is ignored in GAP and UP.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Mole lifetime:
  - `selected_box` takes the new index on the clock edge that enters UP.
  - With no hit it stays exactly UP_CYCLES cycles.
- Hit latency:
  - `hit` seen at edge N → `score` increments and `selected_box` = F after edge N.
  - The hit cycle counts toward the mole's lifetime.
- Hit and timeout in the same cycle: the hit wins and is scored.
- Gap length: exactly GAP_CYCLES cycles of F between moles, and before the first mole.
- `rst` mid-game: immediate asynchronous return to reset values; the LFSR is reseeded.
- Timer width: $clog2(max(UP_CYCLES, GAP_CYCLES)).

## Structure
- Shared package `mole_pkg`: the state enum (IDLE, GAP, UP, DONE), `NO_BOX` = 4'hF, and NUM_BOXES. The screen module uses the same `NO_BOX` value.
- One sub-module, `lfsr8`:
  - Ports: clk, rst, seed parameter, 8-bit output.
  - Free-running.
  - The mod/avoid-repeat logic stays in `mole_game_ctrl`.
- Expected size ~200 lines of RTL.

## Test plan
Bench parameters: UP_CYCLES=20, GAP_CYCLES=5, ROUNDS=3.
- Reset then idle 100 cycles → `selected_box`=F, `score`=0, `round`=0, `game_over`=0 throughout.
- `start` pulse, no hits → F for 5 cycles, a box for exactly 20 cycles, repeated 3 times; then `game_over`=1, `score`=0, `round`=3.
- `start`, hit the active box on its 4th UP cycle each round → `score`=1,2,3; `selected_box`=F on the cycle after each hit; `game_over` after the 3rd gap.
- Wrong-box hit plus a hit during GAP, then the correct hit on the final UP cycle (timer = 0) → only the correct hit is scored (`score`=1 for that round).
- Run 50 games from different `start` times → every `selected_box` value is within 0..9 and no two consecutive moles share an index.
- Assert `rst` mid-UP → outputs return to reset values immediately; a later `start` begins a fresh game with `score`=0.
